ahb_gpio_in_cond: RTL and testbench
===================================

Name: ahb_gpio_in_cond

Overview:
Input-conditioning stage directly upstream of the AHB GPIO peripheral, driving its GPIOIN[16:0] bus. Each of the 16 asynchronous pad inputs passes through a synchroniser and an optional per-bit debouncer. The stable value is registered together with a parity bit such that ^GPIOIN == PARITYSEL, so the peripheral's read path and PARITYERR check see consistent data. Runs on the AHB clock domain.

Parameters:
WIDTH, 16, number of pad data bits; GPIOIN is WIDTH+1 bits.
SYNC_STAGES, 2, synchroniser flop depth (>=2).
DEBOUNCE, 4, consecutive differing samples needed to accept a bit change (>=1).

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  reset, asynchronous, active-low
PADIN  input  WIDTH  raw asynchronous pad inputs
DBEN  input  1  debounce enable (1 = use DEBOUNCE, 0 = bypass)
PARITYSEL  input  1  parity sense: 0 = even, 1 = odd over full GPIOIN
GPIOIN  output  WIDTH+1  [WIDTH-1:0] stable data, [WIDTH] parity bit
CHANGED  output  1  one-cycle pulse when GPIOIN data bits change
IRQMASK  input  WIDTH  per-bit interrupt enable (GPIO_IN_IRQ_EN only)
IRQCLR  input  WIDTH  per-bit status clear pulse (GPIO_IN_IRQ_EN only)
EDGESTAT  output  WIDTH  sticky per-bit change status (GPIO_IN_IRQ_EN only)
IRQ  output  1  |(EDGESTAT & IRQMASK) (GPIO_IN_IRQ_EN only)

Behaviour:
- Reset: HRESETn low clears all state immediately, without waiting for a clock edge: sync chain, counters, GPIOIN=0, CHANGED=0, EDGESTAT=0, IRQ=0.
- Sync: PADIN[i] is captured into stage 0 each edge and shifted through SYNC_STAGES flops; sync[i] is the last stage.
- Debounce, per bit, counter width $clog2(DEBOUNCE+1):
  - sync[i]==GPIOIN[i]: cnt[i]<=0.
  - Differs and cnt[i]==DEBOUNCE-1: GPIOIN[i]<=sync[i], cnt[i]<=0.
  - Otherwise cnt[i] increments.
  - A glitch returning before acceptance resets cnt[i]; no output change.
- DBEN=0: GPIOIN[i]<=sync[i] every edge; counters held at 0. DBEN falling mid-count clears counters. DBEN=0 is cycle-equivalent to DEBOUNCE=1.
- Latency from a PADIN change set up before edge 0:
  - DBEN=1: GPIOIN data updates at edge SYNC_STAGES+DEBOUNCE (6 with defaults).
  - DBEN=0: updates at edge SYNC_STAGES+1 (3 with defaults).
- Parity: GPIOIN[WIDTH] <= PARITYSEL ^ (^data_next) each edge, where data_next is the value being loaded. Invariant after reset: ^GPIOIN equals PARITYSEL sampled at the previous edge. A PARITYSEL change updates only bit WIDTH on the next edge.
- CHANGED: registered; high for exactly the cycle in which GPIOIN[WIDTH-1:0] differs from its previous value. Not asserted for parity-only changes.
- Bits are independent: simultaneous changes on several bits each follow their own counter.

Optional Feature:
Macro GPIO_IN_IRQ_EN.
- Defined: ports IRQMASK, IRQCLR, EDGESTAT, IRQ exist.
  - EDGESTAT[i] is set in the cycle GPIOIN[i] changes, in either direction.
  - EDGESTAT[i] is cleared by IRQCLR[i]=1 at an edge.
  - Set wins over a simultaneous clear.
  - IRQ is combinational from registered EDGESTAT and IRQMASK.
- Undefined: these four ports and the associated logic are absent; the remaining behaviour is identical.

Test Plan:
1. PADIN=16'hFFFF, pulse HRESETn low between edges -> GPIOIN=17'h0, CHANGED=0 immediately, before the next edge; GPIOIN=17'h1FFFF 6 edges after release (DBEN=1).
2. DBEN=0, PARITYSEL=0, PADIN 0->16'h0001 before edge 0 -> GPIOIN=17'h10001 and CHANGED=1 at edge 3 only.
3. DBEN=1, PADIN[3] high for 3 cycles then low -> GPIOIN unchanged, CHANGED never asserted. PADIN[3] high for 4+ cycles -> GPIOIN[3]=1 at edge 6.
4. Data stable at 16'h00FF, PARITYSEL 0->1 -> GPIOIN[16] goes 0->1 one edge later, data unchanged, CHANGED=0.
5. GPIO_IN_IRQ_EN, IRQMASK=16'h0004, PADIN[2] rises -> EDGESTAT=16'h0004 and IRQ=1 when GPIOIN[2] rises. IRQCLR[2] alone -> cleared next edge. IRQCLR[2] coincident with a new GPIOIN[2] change -> stays set.
6. DBEN toggled 1->0 with cnt[5]=2 mid-count -> counter cleared, GPIOIN[5] follows sync[5] at the next edge.

Source files
------------

// File: rtl/ahb_gpio_in_cond_if.sv
// Bus bundle between the pad-conditioning stage and the AHB GPIO peripheral.
// Interrupt-status signals exist only when GPIO_IN_IRQ_EN is defined.
interface ahb_gpio_in_cond_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] PADIN;
  logic             DBEN;
  logic             PARITYSEL;
  logic [WIDTH:0]   GPIOIN;
  logic             CHANGED;
`ifdef GPIO_IN_IRQ_EN
  logic [WIDTH-1:0] IRQMASK;
  logic [WIDTH-1:0] IRQCLR;
  logic [WIDTH-1:0] EDGESTAT;
  logic             IRQ;

  modport master (
    output PADIN, DBEN, PARITYSEL, IRQMASK, IRQCLR,
    input  GPIOIN, CHANGED, EDGESTAT, IRQ
  );
  modport slave (
    input  PADIN, DBEN, PARITYSEL, IRQMASK, IRQCLR,
    output GPIOIN, CHANGED, EDGESTAT, IRQ
  );
`else
  modport master (
    output PADIN, DBEN, PARITYSEL,
    input  GPIOIN, CHANGED
  );
  modport slave (
    input  PADIN, DBEN, PARITYSEL,
    output GPIOIN, CHANGED
  );
`endif
endinterface

// File: rtl/ahb_gpio_in_cond.sv
// Pad input conditioning: synchroniser, per-bit debounce, parity-tagged GPIOIN.
// Optional sticky edge status / IRQ when GPIO_IN_IRQ_EN is defined.
module ahb_gpio_in_cond #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_gpio_in_cond_if.slave  bus
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  function automatic logic parity_bit(input logic sel, input logic [WIDTH-1:0] d);
    return sel ^ (^d);
  endfunction

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             par_q;
  logic             changed_q;

  // Stage p0..pN: metastability chain, PADIN enters at sync_p[0]
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= bus.PADIN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign sync_s = sync_p[SYNC_STAGES-1];

  // A bit is accepted after DEBOUNCE consecutive samples that disagree with the
  // held value; any agreeing sample restarts the run. Bypass loads directly.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (!bus.DBEN) begin
        data_d[i] = sync_s[i];
      end else if (sync_s[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_LAST) data_d[i] = sync_s[i];
        else                      cnt_d[i]  = cnt_q[i] + CW'(1);
      end
    end
  end

  // Stage out: stable data, parity tag and change pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      data_q    <= data_d;
      par_q     <= parity_bit(bus.PARITYSEL, data_d);
      changed_q <= (data_d != data_q);
    end
  end

  assign bus.GPIOIN  = {par_q, data_q};
  assign bus.CHANGED = changed_q;

`ifdef GPIO_IN_IRQ_EN
  logic [WIDTH-1:0] edgestat_q;

  // New edges are OR-ed in after the clear so a coincident edge stays set
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) edgestat_q <= '0;
    else          edgestat_q <= (edgestat_q & ~bus.IRQCLR) | (data_d ^ data_q);
  end

  assign bus.EDGESTAT = edgestat_q;
  assign bus.IRQ      = |(edgestat_q & bus.IRQMASK);
`endif

endmodule

// File: tb/tb_ahb_gpio_in_cond.sv
// Self-checking bench for ahb_gpio_in_cond: vector table, directed corners,
// and randomized traffic against a sample-history reference model.
module tb_ahb_gpio_in_cond;

  localparam int W   = 16;
  localparam int SS  = 2;
  localparam int DEB = 4;

  logic HCLK;
  logic HRESETn;

  ahb_gpio_in_cond_if #(.WIDTH(W)) bus ();

  ahb_gpio_in_cond #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DEB)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PADIN sample pipeline and history of synchronised samples
  logic [W-1:0] padq [SS];
  logic [W-1:0] sh   [DEB];
  logic [W-1:0] m_data;
  logic         m_par;
  logic         m_chg;
  logic [W-1:0] m_es;

  typedef struct {
    logic [W-1:0] padin;
    logic         dben;
    logic         psel;
    int           ncyc;
    logic [W:0]   exp_gpioin;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SS; j++)  padq[j] = '0;
    for (int j = 0; j < DEB; j++) sh[j]   = '0;
    m_data = '0;
    m_par  = 1'b0;
    m_chg  = 1'b0;
    m_es   = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] s, all_diff, nd;
    s = padq[SS-1];
    for (int j = DEB-1; j > 0; j--) sh[j] = sh[j-1];
    sh[0] = s;
    all_diff = '1;
    for (int j = 0; j < DEB; j++) all_diff &= (sh[j] ^ m_data);
    nd = bus.DBEN ? ((m_data & ~all_diff) | (s & all_diff)) : s;
    m_chg = (nd != m_data);
`ifdef GPIO_IN_IRQ_EN
    m_es = (m_es & ~bus.IRQCLR) | (nd ^ m_data);
`endif
    m_par  = bus.PARITYSEL ^ (^nd);
    m_data = nd;
    for (int j = SS-1; j > 0; j--) padq[j] = padq[j-1];
    padq[0] = bus.PADIN;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    chk("model_gpioin",  32'(bus.GPIOIN),  32'({m_par, m_data}));
    chk("model_changed", 32'(bus.CHANGED), 32'(m_chg));
`ifdef GPIO_IN_IRQ_EN
    chk("model_edgestat", 32'(bus.EDGESTAT), 32'(m_es));
    chk("model_irq",      32'(bus.IRQ),      32'(|(m_es & bus.IRQMASK)));
`endif
  endtask

  // Asynchronous reset pulse placed mid low-phase, checked before any edge
  task automatic reset_pulse();
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_gpioin",  32'(bus.GPIOIN),  32'h0);
    chk("rst_changed", 32'(bus.CHANGED), 32'h0);
`ifdef GPIO_IN_IRQ_EN
    chk("rst_edgestat", 32'(bus.EDGESTAT), 32'h0);
    chk("rst_irq",      32'(bus.IRQ),      32'h0);
`endif
    model_reset();
    #1 HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn       = 1'b0;
    bus.PADIN     = '0;
    bus.DBEN      = 1'b1;
    bus.PARITYSEL = 1'b0;
`ifdef GPIO_IN_IRQ_EN
    bus.IRQMASK = '0;
    bus.IRQCLR  = '0;
`endif
    model_reset();
    #12;
    chk("init_gpioin",  32'(bus.GPIOIN),  32'h0);
    chk("init_changed", 32'(bus.CHANGED), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) tick();

    vecs[0] = '{16'h0000, 1'b1, 1'b0, 8, 17'h00000};
    vecs[1] = '{16'h00FF, 1'b1, 1'b0, 8, 17'h000FF};
    vecs[2] = '{16'h00FF, 1'b1, 1'b1, 8, 17'h100FF};
    vecs[3] = '{16'h1234, 1'b0, 1'b0, 8, 17'h11234};
    vecs[4] = '{16'hA5A5, 1'b1, 1'b1, 8, 17'h1A5A5};
    vecs[5] = '{16'hFFFF, 1'b0, 1'b0, 8, 17'h0FFFF};
    vecs[6] = '{16'h8001, 1'b1, 1'b1, 8, 17'h18001};
    vecs[7] = '{16'h7FFF, 1'b1, 1'b0, 8, 17'h17FFF};
    for (int v = 0; v < 8; v++) begin
      bus.PADIN     = vecs[v].padin;
      bus.DBEN      = vecs[v].dben;
      bus.PARITYSEL = vecs[v].psel;
      repeat (vecs[v].ncyc) tick();
      chk($sformatf("vec%0d_gpioin", v), 32'(bus.GPIOIN), 32'(vecs[v].exp_gpioin));
      chk($sformatf("vec%0d_changed", v), 32'(bus.CHANGED), 32'h0);
    end

    // Reset with all pads high, then debounced release latency
    bus.PADIN = 16'hFFFF; bus.DBEN = 1'b1; bus.PARITYSEL = 1'b1;
    reset_pulse();
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("t1_edge%0d", e), 32'(bus.GPIOIN), 32'h10000);
    end
    tick();
    chk("t1_edge6_gpioin",  32'(bus.GPIOIN),  32'h1FFFF);
    chk("t1_edge6_changed", 32'(bus.CHANGED), 32'h1);

    // Bypass latency and single-cycle change pulse
    bus.PADIN = '0; bus.DBEN = 1'b0; bus.PARITYSEL = 1'b0;
    repeat (8) tick();
    bus.PADIN = 16'h0001;
    repeat (2) tick();
    chk("t2_edge2_gpioin", 32'(bus.GPIOIN), 32'h0);
    tick();
    chk("t2_edge3_gpioin",  32'(bus.GPIOIN),  32'h10001);
    chk("t2_edge3_changed", 32'(bus.CHANGED), 32'h1);
    tick();
    chk("t2_edge4_changed", 32'(bus.CHANGED), 32'h0);

    // Short glitch rejected, long pulse accepted
    bus.PADIN = '0; bus.DBEN = 1'b1;
    repeat (8) tick();
    bus.PADIN = 16'h0008;
    repeat (3) tick();
    bus.PADIN = '0;
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("t3_glitch_gpioin",  32'(bus.GPIOIN),  32'h0);
      chk("t3_glitch_changed", 32'(bus.CHANGED), 32'h0);
    end
    bus.PADIN = 16'h0008;
    repeat (5) tick();
    chk("t3_edge5_gpioin", 32'(bus.GPIOIN), 32'h0);
    tick();
    chk("t3_edge6_gpioin",  32'(bus.GPIOIN),  32'h10008);
    chk("t3_edge6_changed", 32'(bus.CHANGED), 32'h1);

    // Parity-sense change alone
    bus.PADIN = 16'h00FF; bus.PARITYSEL = 1'b0;
    repeat (8) tick();
    bus.PARITYSEL = 1'b1;
    tick();
    chk("t4_gpioin",  32'(bus.GPIOIN),  32'h100FF);
    chk("t4_changed", 32'(bus.CHANGED), 32'h0);

    // DBEN dropped while a count is in progress
    bus.PADIN = '0; bus.PARITYSEL = 1'b0; bus.DBEN = 1'b1;
    repeat (8) tick();
    bus.PADIN = 16'h0020;
    repeat (4) tick();
    chk("t6_edge4_gpioin", 32'(bus.GPIOIN), 32'h0);
    bus.DBEN = 1'b0;
    tick();
    chk("t6_edge5_gpioin",  32'(bus.GPIOIN),  32'h10020);
    chk("t6_edge5_changed", 32'(bus.CHANGED), 32'h1);

`ifdef GPIO_IN_IRQ_EN
    // Edge status, clear, and set-over-clear
    bus.PADIN = '0; bus.DBEN = 1'b0; bus.IRQMASK = 16'h0004;
    repeat (6) tick();
    bus.IRQCLR = '1;
    tick();
    bus.IRQCLR = '0;
    bus.PADIN = 16'h0004;
    repeat (3) tick();
    chk("t5_rise_edgestat", 32'(bus.EDGESTAT), 32'h0004);
    chk("t5_rise_irq",      32'(bus.IRQ),      32'h1);
    bus.IRQCLR = 16'h0004;
    tick();
    chk("t5_clr_edgestat", 32'(bus.EDGESTAT), 32'h0);
    chk("t5_clr_irq",      32'(bus.IRQ),      32'h0);
    bus.IRQCLR = '0;
    bus.PADIN = '0;
    repeat (2) tick();
    bus.IRQCLR = 16'h0004;
    tick();
    chk("t5_setwins_edgestat", 32'(bus.EDGESTAT), 32'h0004);
    chk("t5_setwins_irq",      32'(bus.IRQ),      32'h1);
    bus.IRQCLR = '0;
`endif

    // Randomized traffic with sparse bit flips so some changes survive debounce
    bus.DBEN = 1'b1;
    for (int it = 0; it < 800; it++) begin
      logic [W-1:0] flip;
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
      bus.PADIN = bus.PADIN ^ flip;
      if ($urandom_range(0, 24) == 0) bus.DBEN = ~bus.DBEN;
      if ($urandom_range(0, 15) == 0) bus.PARITYSEL = ~bus.PARITYSEL;
`ifdef GPIO_IN_IRQ_EN
      bus.IRQMASK = 16'($urandom);
      bus.IRQCLR  = 16'($urandom & $urandom & $urandom);
`endif
      if (it == 400) reset_pulse();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
